// File: rtl/complex_alu_arb.sv
// -----------------------------------------------------------------------------
// complex_alu_arb
//
// Two-requester round-robin arbiter in front of a single complex-number ALU.
// A granted request is captured in IDLE. The ALU evaluates it in EXEC. The
// result is then held in RESP until the consumer takes it. One operation is in
// flight at a time, and the best-case throughput is one operation every three
// cycles.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [1:0] per-requester request valid
//   req_op     : [1:0] per-requester op (0 = complex add, 1 = complex multiply)
//   req_a_re   : [2*WIDTH-1:0] operand A real, requester i at [i*WIDTH +: WIDTH]
//   req_a_im   : [2*WIDTH-1:0] operand A imag
//   req_b_re   : [2*WIDTH-1:0] operand B real
//   req_b_im   : [2*WIDTH-1:0] operand B imag
//   req_ready  : [1:0] per-requester accept strobe (combinational, IDLE only)
//   res_valid  : result valid (registered)
//   res_ready  : result consumer ready
//   res_id     : requester index of the held result
//   res_op     : op of the held result
//   res_re     : [WIDTH-1:0] signed result real part (wrapped)
//   res_im     : [WIDTH-1:0] signed result imag part (wrapped)
//   busy       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module complex_alu_arb #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a_re,
  input  logic [2*WIDTH-1:0] req_a_im,
  input  logic [2*WIDTH-1:0] req_b_re,
  input  logic [2*WIDTH-1:0] req_b_im,
  output logic [1:0]         req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic               res_op,
  output logic [WIDTH-1:0]   res_re,
  output logic [WIDTH-1:0]   res_im,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic               last_grant_r;
  logic               id_r;
  logic               op_r;
  logic [WIDTH-1:0]   a_re_r;
  logic [WIDTH-1:0]   a_im_r;
  logic [WIDTH-1:0]   b_re_r;
  logic [WIDTH-1:0]   b_im_r;
  logic               res_valid_r;
  logic               res_id_r;
  logic               res_op_r;
  logic [WIDTH-1:0]   res_re_r;
  logic [WIDTH-1:0]   res_im_r;
  logic               busy_r;

  logic               grant_id_s;
  logic [1:0]         req_ready_s;
  logic               accept_s;
  logic               sel_op_s;
  logic [WIDTH-1:0]   sel_a_re_s;
  logic [WIDTH-1:0]   sel_a_im_s;
  logic [WIDTH-1:0]   sel_b_re_s;
  logic [WIDTH-1:0]   sel_b_im_s;
  logic [WIDTH-1:0]   calc_re_s;
  logic [WIDTH-1:0]   calc_im_s;

  // Round-robin pick: a contended request goes to the requester not served last;
  // a lone request always wins whatever the history.
  always_comb begin
    grant_id_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id_s = ~last_grant_r;
    end else if (req_valid[0]) begin
      grant_id_s = 1'b0;
    end else begin
      grant_id_s = 1'b1;
    end
  end

  // Accept strobe. It is only possible in IDLE. It is gated by rst_n so that it
  // stays low during reset even when requests are pending.
  always_comb begin
    req_ready_s = 2'b00;
    if (rst_n && (state_r == IDLE) && (req_valid != 2'b00)) begin
      if (grant_id_s) begin
        req_ready_s = 2'b10;
      end else begin
        req_ready_s = 2'b01;
      end
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign accept_s = |req_ready_s;

  // Route the granted requester's operand slices to the capture registers.
  always_comb begin
    sel_op_s   = 1'b0;
    sel_a_re_s = '0;
    sel_a_im_s = '0;
    sel_b_re_s = '0;
    sel_b_im_s = '0;
    if (grant_id_s) begin
      sel_op_s   = req_op[1];
      sel_a_re_s = req_a_re[2*WIDTH-1:WIDTH];
      sel_a_im_s = req_a_im[2*WIDTH-1:WIDTH];
      sel_b_re_s = req_b_re[2*WIDTH-1:WIDTH];
      sel_b_im_s = req_b_im[2*WIDTH-1:WIDTH];
    end else begin
      sel_op_s   = req_op[0];
      sel_a_re_s = req_a_re[WIDTH-1:0];
      sel_a_im_s = req_a_im[WIDTH-1:0];
      sel_b_re_s = req_b_re[WIDTH-1:0];
      sel_b_im_s = req_b_im[WIDTH-1:0];
    end
  end

  // Complex add or multiply on the captured operands.
  // The low WIDTH bits of a two's-complement product or sum depend only on
  // the low WIDTH bits of its operands. WIDTH-wide arithmetic therefore
  // produces exactly the low WIDTH bits of the full 2*WIDTH-precision result.
  // That is the wrapped value returned, with no saturation.
  always_comb begin
    calc_re_s = '0;
    calc_im_s = '0;
    case (op_r)
      1'b0: begin
        calc_re_s = a_re_r + b_re_r;
        calc_im_s = a_im_r + b_im_r;
      end
      1'b1: begin
        calc_re_s = (a_re_r * b_re_r) - (a_im_r * b_im_r);
        calc_im_s = (a_re_r * b_im_r) + (a_im_r * b_re_r);
      end
      default: begin
        calc_re_s = '0;
        calc_im_s = '0;
      end
    endcase
  end

  // Main FSM. It captures requests, registers ALU results and runs the result
  // handshake. Reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      op_r         <= 1'b0;
      a_re_r       <= '0;
      a_im_r       <= '0;
      b_re_r       <= '0;
      b_im_r       <= '0;
      res_valid_r  <= 1'b0;
      res_id_r     <= 1'b0;
      res_op_r     <= 1'b0;
      res_re_r     <= '0;
      res_im_r     <= '0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r         <= grant_id_s;
            op_r         <= sel_op_s;
            a_re_r       <= sel_a_re_s;
            a_im_r       <= sel_a_im_s;
            b_re_r       <= sel_b_re_s;
            b_im_r       <= sel_b_im_s;
            last_grant_r <= grant_id_s;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end else begin
            state_r      <= IDLE;
          end
        end
        EXEC: begin
          res_re_r    <= calc_re_s;
          res_im_r    <= calc_im_s;
          res_id_r    <= id_r;
          res_op_r    <= op_r;
          res_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_op    = res_op_r;
  assign res_re    = res_re_r;
  assign res_im    = res_im_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_complex_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_complex_alu_arb
//
// Directed testbench for complex_alu_arb with WIDTH = 16. Single transactions
// come from a table of hand-computed vectors. Arbitration, backpressure and
// mid-operation reset are exercised as hand-written sequences. Inputs change
// 1 ns after a rising edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_complex_alu_arb;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_op;
  logic [2*W-1:0] req_a_re;
  logic [2*W-1:0] req_a_im;
  logic [2*W-1:0] req_b_re;
  logic [2*W-1:0] req_b_im;
  logic [1:0]     req_ready;
  logic           res_valid;
  logic           res_ready;
  logic           res_id;
  logic           res_op;
  logic [W-1:0]   res_re;
  logic [W-1:0]   res_im;
  logic           busy;

  int n_checks;
  int n_fail;

  typedef struct {
    logic         id;
    logic         op;
    logic [W-1:0] a_re;
    logic [W-1:0] a_im;
    logic [W-1:0] b_re;
    logic [W-1:0] b_im;
    logic [W-1:0] e_re;
    logic [W-1:0] e_im;
  } vec_t;

  vec_t vecs [7];

  complex_alu_arb #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a_re  (req_a_re),
    .req_a_im  (req_a_im),
    .req_b_re  (req_b_re),
    .req_b_im  (req_b_im),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_op    (res_op),
    .res_re    (res_re),
    .res_im    (res_im),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load one requester's slice and fill the other requester's slice with junk.
  task automatic load_req(input logic id, input logic op,
                          input logic [W-1:0] a_re, input logic [W-1:0] a_im,
                          input logic [W-1:0] b_re, input logic [W-1:0] b_im);
    if (id) begin
      req_a_re = {a_re, 16'hDEAD};
      req_a_im = {a_im, 16'hBEEF};
      req_b_re = {b_re, 16'h1357};
      req_b_im = {b_im, 16'h2468};
      req_op   = {op, ~op};
    end else begin
      req_a_re = {16'hDEAD, a_re};
      req_a_im = {16'hBEEF, a_im};
      req_b_re = {16'h1357, b_re};
      req_b_im = {16'h2468, b_im};
      req_op   = {~op, op};
    end
  endtask

  // One transaction from IDLE. The caller enters 1 ns after a rising edge.
  // The operands are scrambled after acceptance, so the result must still
  // come from the values that were captured.
  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] exp_rdy;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    load_req(v.id, v.op, v.a_re, v.a_im, v.b_re, v.b_im);
    req_valid = exp_rdy;
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, " req_ready idle"}, {30'd0, req_ready}, {30'd0, exp_rdy});
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_a_re  = ~req_a_re;
    req_b_im  = ~req_b_im;
    req_op    = ~req_op;
    @(negedge clk);
    chk({tag, " exec res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " exec busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " exec req_ready"}, {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk({tag, " resp res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, " res_id"}, {31'd0, res_id}, {31'd0, v.id});
    chk({tag, " res_op"}, {31'd0, res_op}, {31'd0, v.op});
    chk({tag, " res_re"}, {16'd0, res_re}, {16'd0, v.e_re});
    chk({tag, " res_im"}, {16'd0, res_im}, {16'd0, v.e_im});
    @(negedge clk);
    chk({tag, " idle res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0] exp_rdy;
    n_checks = 0;
    n_fail   = 0;

    // id, op, a_re, a_im, b_re, b_im, expected re, expected im
    vecs[0] = '{1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0001, 16'h0002, 16'h0004, 16'h0006};
    vecs[1] = '{1'b1, 1'b1, 16'h0003, 16'h0004, 16'h0001, 16'h0002, 16'hFFFB, 16'h000A};
    vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0002};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
    vecs[6] = '{1'b0, 1'b1, 16'h0123, 16'h0002, 16'h0010, 16'hFFFF, 16'h1232, 16'hFEFD};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b0;
    load_req(1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0001, 16'h0002);
    req_a_re[2*W-1:W] = 16'h0003;
    req_a_im[2*W-1:W] = 16'h0004;
    req_b_re[2*W-1:W] = 16'h0001;
    req_b_im[2*W-1:W] = 16'h0002;
    repeat (2) @(negedge clk);

    // The outputs are in their reset state even with requests pending.
    chk("reset req_ready", {30'd0, req_ready}, 32'd0);
    chk("reset res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset res_id", {31'd0, res_id}, 32'd0);
    chk("reset res_op", {31'd0, res_op}, 32'd0);
    chk("reset res_re", {16'd0, res_re}, 32'd0);
    chk("reset res_im", {16'd0, res_im}, 32'd0);

    // Both requesters stay valid from reset release. Grants are one-cycle
    // pulses every third cycle and alternate 0, 1, 0, 1.
    @(posedge clk); #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ((k % 3) == 0) begin
        exp_rdy = (((k / 3) % 2) == 0) ? 2'b01 : 2'b10;
      end else begin
        exp_rdy = 2'b00;
      end
      chk($sformatf("rr req_ready cyc%0d", k), {30'd0, req_ready}, {30'd0, exp_rdy});
      if ((k % 3) == 2) begin
        chk($sformatf("rr res_id cyc%0d", k), {31'd0, res_id}, {31'd0, ((k / 3) % 2 == 1)});
      end
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure. Requester 0 adds (5,6)+(7,8) = (12,14) while res_ready is
    // low. Requester 1 then raises a request for (2,0)*(3,0) = (6,0), which
    // must stay pending until the held result has been taken.
    load_req(1'b0, 1'b0, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    req_valid = 2'b01;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp accept0", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    load_req(1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0003, 16'h0000);
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp exec req_ready", {30'd0, req_ready}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold res_valid %0d", k), {31'd0, res_valid}, 32'd1);
      chk($sformatf("bp hold res_re %0d", k), {16'd0, res_re}, 32'h000C);
      chk($sformatf("bp hold res_im %0d", k), {16'd0, res_im}, 32'h000E);
      chk($sformatf("bp hold res_id %0d", k), {31'd0, res_id}, 32'd0);
      chk($sformatf("bp hold req_ready %0d", k), {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp release res_valid", {31'd0, res_valid}, 32'd1);
    @(negedge clk);
    chk("bp idle res_valid", {31'd0, res_valid}, 32'd0);
    chk("bp pending grant", {30'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("bp req1 res_valid", {31'd0, res_valid}, 32'd1);
    chk("bp req1 res_id", {31'd0, res_id}, 32'd1);
    chk("bp req1 res_op", {31'd0, res_op}, 32'd1);
    chk("bp req1 res_re", {16'd0, res_re}, 32'h0006);
    chk("bp req1 res_im", {16'd0, res_im}, 32'h0000);
    @(posedge clk); #1;

    // Reset pulse in the middle of EXEC. It clears everything at once, even
    // with a request still pending, and no result follows after release.
    load_req(1'b0, 1'b1, 16'h0003, 16'h0004, 16'h0001, 16'h0002);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst accept", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #2;
    chk("rst pre busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst async res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst async busy", {31'd0, busy}, 32'd0);
    chk("rst async res_id", {31'd0, res_id}, 32'd0);
    chk("rst async res_op", {31'd0, res_op}, 32'd0);
    chk("rst async res_re", {16'd0, res_re}, 32'd0);
    chk("rst async res_im", {16'd0, res_im}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst post res_valid %0d", k), {31'd0, res_valid}, 32'd0);
      chk($sformatf("rst post busy %0d", k), {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    run_vec(vecs[1], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_alu_arb.md
COMPLEX_ALU_ARB -- requirements
Module: complex_alu_arb

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of each signed real/imag operand and result component.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_op  input  2  per-requester op select; 0 = complex add, 1 = complex multiply.
REQ-006 req_a_re, req_a_im, req_b_re, req_b_im  input  2*WIDTH each  signed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  2  per-requester accept strobe; at most one bit high per cycle.
REQ-008 res_valid  output  1  result valid.
REQ-009 res_ready  input  1  result consumer ready.
REQ-010 res_id  output  1  index of requester that issued the result.
REQ-011 res_op  output  1  op of the result.
REQ-012 res_re, res_im  output  WIDTH each  signed result components.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid bit is high, grant one requester, drive its req_ready high combinationally that cycle, capture its operands/op/id, go to EXEC; otherwise stay.
REQ-016 Handshake: a transfer occurs only when req_valid[i] and req_ready[i] are both high; req_ready SHALL be 0 in EXEC and RESP.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-018 Last-grant pointer SHALL update only on an accepted transfer.
REQ-019 EXEC: compute from captured operands in one cycle, register result, go to RESP.
REQ-020 Add: re = a_re + b_re, im = a_im + b_im.
REQ-021 Multiply: re = a_re*b_re - a_im*b_im, im = a_re*b_im + a_im*b_re; products at full 2*WIDTH precision.
REQ-022 Results SHALL be truncated to the low WIDTH bits (two's-complement wrap, no saturation).
REQ-023 RESP: res_valid high; res_id/res_op/res_re/res_im stable until res_valid && res_ready; on that cycle go to IDLE.
REQ-024 Latency: transfer at edge T -> res_valid high from cycle T+2; with res_ready held high the next acceptance is possible at T+3 (one op per 3 cycles).
REQ-025 Backpressure: res_ready low holds RESP indefinitely; requesters remain un-ready and their requests are not lost (they stay pending).
REQ-026 res_valid SHALL be 0 in IDLE and EXEC; result registers hold last value outside RESP.
REQ-027 Changes on req_* inputs after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, req_ready=0, res_valid=0, busy=0, res_id=0, res_op=0, res_re=0, res_im=0.
REQ-029 Reset SHALL set the last-grant pointer to 1 so requester 0 wins the first contended arbitration.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no result is emitted after release.
REQ-031 After rst_n deasserts, the first transfer is possible on the first rising edge.

Verification
REQ-032 Req0 add a=(3,4), b=(1,2), res_ready=1 -> res_valid at T+2, res_id=0, res=(4,6), res_op=0.
REQ-033 Req1 mul a=(3,4), b=(1,2) -> res=(-5,10), res_id=1; with WIDTH=16 a=(16'h7FFF,0) add b=(1,0) -> res_re=16'h8000.
REQ-034 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; each req_ready pulse exactly one cycle.
REQ-035 res_ready held low 10 cycles in RESP -> res_* stable, req_ready=0 throughout; release -> IDLE next cycle, pending request granted.
REQ-036 rst_n pulsed low mid-EXEC -> all outputs 0 immediately (asynchronously); no res_valid after release until a new request.
